hue_stream_arbiter: RTL

- Shares one hsv_top hue pipeline (RGB565 in, hue out, fixed latency, no backpressure) between two pixel streams, A and B.
- Arbitrates round-robin between the streams and registers the winning pixel into the core.
- Carries a source tag alongside each pixel through a matched-latency shift register, and routes core results back to per-stream outputs.
- Also provides per-stream enables, accepted-pixel counters and a sticky latency-mismatch error.

---
 rtl/hue_arb_pkg.sv | 27 ++
 rtl/hue_tag_pipe.sv | 53 +++++
 rtl/hue_stream_arbiter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/hue_arb_pkg.sv
//==============================================================================
// Package : hue_arb_pkg
// Shared widths, source tags and grant helper for the hue stream arbiter.
// Rev     : 1.0
//==============================================================================
`default_nettype none

package hue_arb_pkg;

  localparam int PIX_W            = 16;
  localparam int HUE_W            = 16;
  localparam int DEF_CORE_LATENCY = 3;

  typedef logic tag_t;

  localparam tag_t TAG_A = 1'b0;
  localparam tag_t TAG_B = 1'b1;

  // B wins when it is the only eligible stream, or on contention when A went last.
  function automatic logic grant_b(input logic elig_a, input logic elig_b,
                                   input tag_t last_grant);
    return elig_b && (!elig_a || (last_grant == TAG_A));
  endfunction

endpackage

`default_nettype wire

// File: rtl/hue_tag_pipe.sv
//==============================================================================
// Module : hue_tag_pipe
// Parameterised-depth {valid, tag} shift register tracking pixels in the core.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module hue_tag_pipe
  import hue_arb_pkg::*;
#(
  parameter int DEPTH = DEF_CORE_LATENCY
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_valid,
  input  tag_t i_tag,
  output logic o_tail_valid,
  output tag_t o_tail_tag
);

  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] r_tag;

  generate
    if (DEPTH == 1) begin : g_single
      always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
          r_valid <= '0;
          r_tag   <= '0;
        end else begin
          r_valid[0] <= i_valid;
          r_tag[0]   <= i_tag;
        end
      end
    end else begin : g_multi
      always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
          r_valid <= '0;
          r_tag   <= '0;
        end else begin
          r_valid <= {r_valid[DEPTH-2:0], i_valid};
          r_tag   <= {r_tag[DEPTH-2:0], i_tag};
        end
      end
    end
  endgenerate

  assign o_tail_valid = r_valid[DEPTH-1];
  assign o_tail_tag   = r_tag[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/hue_stream_arbiter.sv
//==============================================================================
// Module : hue_stream_arbiter
// Round-robin sharing of one fixed-latency hue core between pixel streams A/B.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module hue_stream_arbiter
  import hue_arb_pkg::*;
#(
  parameter int CORE_LATENCY = DEF_CORE_LATENCY,
  parameter int CNT_W        = 16
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic [1:0]       i_en,
  input  logic [PIX_W-1:0] i_a_data,
  input  logic             i_a_valid,
  output logic             o_a_ready,
  input  logic [PIX_W-1:0] i_b_data,
  input  logic             i_b_valid,
  output logic             o_b_ready,
  output logic [PIX_W-1:0] o_core_data,
  output logic             o_core_valid,
  input  logic [HUE_W-1:0] i_core_data,
  input  logic             i_core_valid,
  output logic [HUE_W-1:0] o_a_hue,
  output logic             o_a_valid,
  output logic [HUE_W-1:0] o_b_hue,
  output logic             o_b_valid,
  output logic [CNT_W-1:0] o_a_count,
  output logic [CNT_W-1:0] o_b_count,
  output logic             o_err
);

  logic             w_elig_a;
  logic             w_elig_b;
  logic             w_grant_b;
  logic             w_xfer_a;
  logic             w_xfer_b;
  logic             w_tail_valid;
  tag_t             w_tail_tag;
  logic             w_hit_a;
  logic             w_hit_b;

  tag_t             r_last_grant;
  tag_t             r_core_tag;
  logic [PIX_W-1:0] r_core_data;
  logic             r_core_valid;
  logic [HUE_W-1:0] r_a_hue;
  logic [HUE_W-1:0] r_b_hue;
  logic             r_a_valid;
  logic             r_b_valid;
  logic [CNT_W-1:0] r_a_count;
  logic [CNT_W-1:0] r_b_count;
  logic             r_err;

  // Readies are held low while reset is asserted so nothing handshakes then.
  always_comb begin
    w_elig_a  = i_a_valid & i_en[0];
    w_elig_b  = i_b_valid & i_en[1];
    w_grant_b = grant_b(w_elig_a, w_elig_b, r_last_grant);
    o_a_ready = 1'b0;
    o_b_ready = 1'b0;
    if (i_rstn) begin
      o_a_ready = w_elig_a & ~w_grant_b;
      o_b_ready = w_grant_b;
    end
  end

  assign w_xfer_a = i_a_valid & o_a_ready;
  assign w_xfer_b = i_b_valid & o_b_ready;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_core_data  <= '0;
      r_core_valid <= 1'b0;
      r_core_tag   <= TAG_A;
      r_last_grant <= TAG_B;
    end else begin
      r_core_valid <= w_xfer_a | w_xfer_b;
      if (w_xfer_a) begin
        r_core_data  <= i_a_data;
        r_core_tag   <= TAG_A;
        r_last_grant <= TAG_A;
      end else if (w_xfer_b) begin
        r_core_data  <= i_b_data;
        r_core_tag   <= TAG_B;
        r_last_grant <= TAG_B;
      end
    end
  end

  // The core-input register is the first tag stage; CORE_LATENCY further
  // stages bring the tail level with the core's result valid.
  hue_tag_pipe #(
    .DEPTH (CORE_LATENCY)
  ) u_tag_pipe (
    .i_clk        (i_clk),
    .i_rstn       (i_rstn),
    .i_valid      (r_core_valid),
    .i_tag        (r_core_tag),
    .o_tail_valid (w_tail_valid),
    .o_tail_tag   (w_tail_tag)
  );

  assign w_hit_a = i_core_valid & w_tail_valid & (w_tail_tag == TAG_A);
  assign w_hit_b = i_core_valid & w_tail_valid & (w_tail_tag == TAG_B);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_a_valid <= 1'b0;
      r_b_valid <= 1'b0;
      r_a_hue   <= '0;
      r_b_hue   <= '0;
      r_err     <= 1'b0;
    end else begin
      r_a_valid <= w_hit_a;
      r_b_valid <= w_hit_b;
      if (w_hit_a) r_a_hue <= i_core_data;
      if (w_hit_b) r_b_hue <= i_core_data;
      r_err <= r_err | (i_core_valid ^ w_tail_valid);
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_a_count <= '0;
      r_b_count <= '0;
    end else begin
      if (w_xfer_a && (r_a_count != '1)) r_a_count <= r_a_count + CNT_W'(1);
      if (w_xfer_b && (r_b_count != '1)) r_b_count <= r_b_count + CNT_W'(1);
    end
  end

  assign o_core_data  = r_core_data;
  assign o_core_valid = r_core_valid;
  assign o_a_hue      = r_a_hue;
  assign o_a_valid    = r_a_valid;
  assign o_b_hue      = r_b_hue;
  assign o_b_valid    = r_b_valid;
  assign o_a_count    = r_a_count;
  assign o_b_count    = r_b_count;
  assign o_err        = r_err;

endmodule

`default_nettype wire
